// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port byte RAM between a CPU (byte/half/word,
// big-endian, multi-beat) and a host loader (single byte). Round-robin on ties,
// one transfer at a time, registered outputs.
module dmem_arbiter #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;
  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        n_q, n_d;
  logic [1:0]        k_q, k_d;
  logic [23:0]       acc_q, acc_d;
  logic              grant_host;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              cpu_done_q, cpu_done_d;
  logic              host_done_q, host_done_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        host_rdata_q, host_rdata_d;

  // Big-endian beat selection: beat k of an n-byte operand carries byte n-1-k.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [2:0] n,
                                          input logic [1:0] k);
    logic [1:0] idx;
    idx = 2'(n - 3'd1 - {1'b0, k});
    return w[{idx, 3'b000} +: 8];
  endfunction

  // Next-state, beat sequencing and read assembly.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    n_d          = n_q;
    k_d          = k_q;
    acc_d        = acc_q;
    grant_host   = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_done_d   = 1'b0;
    host_done_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    case (state_q)
      IDLE: begin
        if (cpu_req || host_req) begin
          // On a tie the requester that did not go last wins.
          grant_host   = (cpu_req && host_req) ? ~last_owner_q : host_req;
          owner_d      = grant_host;
          last_owner_d = grant_host;
          if (grant_host == OWN_HOST) begin
            we_d    = host_we;
            addr_d  = host_addr;
            wdata_d = {24'd0, host_wdata};
            n_d     = 3'd1;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            case (cpu_size)
              2'd0:    n_d = 3'd1;
              2'd1:    n_d = 3'd2;
              default: n_d = 3'd4;
            endcase
          end
          k_d         = 2'd0;
          acc_d       = 24'd0;
          state_d     = XFER;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          mem_addr_d  = addr_d;
          mem_wdata_d = byte_sel(wdata_d, n_d, 2'd0);
        end
      end
      XFER: begin
        // Read data of the previous beat arrives during this beat.
        if (!we_q && k_q != 2'd0)
          acc_d = {acc_q[15:0], mem_rdata};
        if (({1'b0, k_q} + 3'd1) == n_q) begin
          if (we_q) begin
            state_d     = DONE;
            cpu_done_d  = (owner_q == OWN_CPU);
            host_done_d = (owner_q == OWN_HOST);
          end else begin
            state_d = DRAIN;
          end
        end else begin
          k_d         = k_q + 2'd1;
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_q + ADDR_W'({1'b0, k_q} + 3'd1);
          mem_wdata_d = byte_sel(wdata_q, n_q, k_d);
        end
      end
      DRAIN: begin
        // Final byte lands; upper bytes are zero because acc starts cleared.
        if (owner_q == OWN_CPU) begin
          cpu_rdata_d = {acc_q, mem_rdata};
          cpu_done_d  = 1'b1;
        end else begin
          host_rdata_d = mem_rdata;
          host_done_d  = 1'b1;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset clears control and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_HOST;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'd0;
      busy_q       <= 1'b0;
      cpu_done_q   <= 1'b0;
      host_done_q  <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      host_rdata_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      cpu_done_q   <= cpu_done_d;
      host_done_q  <= host_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Operand and beat bookkeeping carry no reset; they are loaded on every grant.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    n_q     <= n_d;
    k_q     <= k_d;
    acc_q   <= acc_d;
  end

  // Outputs are forced low for the whole reset cycle so an aborted beat never writes.
  assign mem_en     = mem_en_q & ~rst;
  assign mem_we     = mem_we_q & ~rst;
  assign mem_addr   = rst ? '0 : mem_addr_q;
  assign mem_wdata  = rst ? 8'd0 : mem_wdata_q;
  assign busy       = busy_q & ~rst;
  assign cpu_done   = cpu_done_q & ~rst;
  assign host_done  = host_done_q & ~rst;
  assign cpu_rdata  = rst ? 32'd0 : cpu_rdata_q;
  assign host_rdata = rst ? 8'd0 : host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against a transaction-timeline model of the
// arbiter, with a byte RAM attached to the memory port.
module tb_dmem_arbiter;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [1:0]    cpu_size = 2'd0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = 32'd0;
  logic [31:0]   cpu_rdata;
  logic          cpu_done;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = 8'd0;
  logic [7:0]    host_rdata;
  logic          host_done;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'd0;
  logic          busy;

  dmem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_done(host_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Byte RAM: synchronous write, one-cycle read latency.
  logic [7:0] ram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) ram[i] = 8'd0;
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  // Model: each grant expands into a per-cycle timeline of expected outputs.
  typedef struct packed {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          busy;
    logic          cdone;
    logic          hdone;
    logic          upd;
    logic [31:0]   rd;
  } rec_t;

  rec_t        tl[$];
  rec_t        cur = '0;
  logic [7:0]  mmem [0:(1<<AW)-1];
  logic        m_last = 1'b1;
  logic [31:0] exp_cpu_rd = 32'd0;
  logic [7:0]  exp_host_rd = 8'd0;
  initial for (int i = 0; i < (1 << AW); i++) mmem[i] = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      tl.delete();
      cur = '0;
      m_last = 1'b1;
      exp_cpu_rd = 32'd0;
      exp_host_rd = 8'd0;
    end else begin
      if (tl.size() == 0 && (cpu_req || host_req)) begin
        logic g, w;
        logic [AW-1:0] a;
        logic [31:0] wd, rd;
        int n;
        rec_t r;
        g = (cpu_req && host_req) ? !m_last : host_req;
        m_last = g;
        if (g) begin w = host_we; a = host_addr; wd = {24'd0, host_wdata}; n = 1; end
        else begin
          w = cpu_we; a = cpu_addr; wd = cpu_wdata;
          n = (cpu_size == 2'd0) ? 1 : (cpu_size == 2'd1) ? 2 : 4;
        end
        rd = 32'd0;
        for (int k = 0; k < n; k++) rd = (rd << 8) | {24'd0, mmem[AW'(int'(a) + k)]};
        for (int k = 0; k < n; k++) begin
          r = '0;
          r.en = 1'b1; r.we = w; r.busy = 1'b1;
          r.addr = AW'(int'(a) + k);
          r.wdata = 8'(wd >> (8 * (n - 1 - k)));
          tl.push_back(r);
        end
        if (!w) begin r = '0; r.busy = 1'b1; tl.push_back(r); end
        r = '0; r.busy = 1'b1; r.cdone = !g; r.hdone = g; r.upd = !w; r.rd = rd;
        tl.push_back(r);
        r = '0;
        tl.push_back(r);
      end
      cur = (tl.size() > 0) ? tl.pop_front() : rec_t'('0);
      if (cur.upd && cur.cdone) exp_cpu_rd = cur.rd;
      if (cur.upd && cur.hdone) exp_host_rd = cur.rd[7:0];
    end
  end

  // Compare every cycle, away from the clock edge.
  int cpu_done_cnt = 0, host_done_cnt = 0, double_pulse = 0;
  logic prev_cd = 1'b0, prev_hd = 1'b0;
  always @(negedge clk) begin
    rec_t e;
    e = rst ? rec_t'('0) : cur;
    chk("mem_en", {31'd0, mem_en}, {31'd0, e.en});
    chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
    if (e.en) begin
      chk("mem_addr", {26'd0, mem_addr}, {26'd0, e.addr});
      chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
    end
    chk("busy", {31'd0, busy}, {31'd0, e.busy});
    chk("cpu_done", {31'd0, cpu_done}, {31'd0, e.cdone});
    chk("host_done", {31'd0, host_done}, {31'd0, e.hdone});
    chk("cpu_rdata", cpu_rdata, rst ? 32'd0 : exp_cpu_rd);
    chk("host_rdata", {24'd0, host_rdata}, rst ? 32'd0 : {24'd0, exp_host_rd});
    if (!rst && e.en && e.we) mmem[e.addr] = e.wdata;
    if (cpu_done) cpu_done_cnt++;
    if (host_done) host_done_cnt++;
    if ((cpu_done && prev_cd) || (host_done && prev_hd)) double_pulse++;
    prev_cd = cpu_done;
    prev_hd = host_done;
  end

  // One request, held until its done pulse; lat counts cycles from the grant edge.
  task automatic do_op(input bit is_host, input bit we, input logic [1:0] sz,
                       input logic [AW-1:0] a, input logic [31:0] wd, output int lat);
    @(posedge clk); #1;
    if (is_host) begin host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd[7:0]; end
    else begin cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_addr = a; cpu_wdata = wd; end
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((is_host ? host_done : cpu_done) == 1'b1) begin lat = i; break; end
      @(posedge clk);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    host_req = 1'b0;
  endtask

  initial begin
    int lat, cnt0;
    logic [3:0] seq;
    int nseq;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
    chk("reset_cpu_rdata", cpu_rdata, 32'd0);
    chk("reset_host_rdata", {24'd0, host_rdata}, 32'd0);

    // Word store then load.
    do_op(1'b0, 1'b1, 2'd2, 6'd8, 32'h11223344, lat);
    chk("st_word_lat", 32'(lat), 32'd5);
    chk("ram8", {24'd0, ram[8]}, 32'h11);
    chk("ram9", {24'd0, ram[9]}, 32'h22);
    chk("ram10", {24'd0, ram[10]}, 32'h33);
    chk("ram11", {24'd0, ram[11]}, 32'h44);
    do_op(1'b0, 1'b0, 2'd2, 6'd8, 32'd0, lat);
    chk("ld_word_lat", 32'(lat), 32'd6);
    chk("ld_word", cpu_rdata, 32'h11223344);
    do_op(1'b0, 1'b0, 2'd3, 6'd8, 32'd0, lat);
    chk("ld_size3", cpu_rdata, 32'h11223344);

    // Host byte writes, then half/byte loads.
    do_op(1'b1, 1'b1, 2'd0, 6'd20, 32'hAB, lat);
    chk("host_wr_lat", 32'(lat), 32'd2);
    do_op(1'b1, 1'b1, 2'd0, 6'd21, 32'hCD, lat);
    do_op(1'b0, 1'b0, 2'd1, 6'd20, 32'd0, lat);
    chk("ld_half_lat", 32'(lat), 32'd4);
    chk("ld_half", cpu_rdata, 32'h0000ABCD);
    do_op(1'b0, 1'b0, 2'd0, 6'd21, 32'd0, lat);
    chk("ld_byte", cpu_rdata, 32'h000000CD);
    do_op(1'b1, 1'b0, 2'd0, 6'd20, 32'd0, lat);
    chk("host_rd_lat", 32'(lat), 32'd3);
    chk("host_rd", {24'd0, host_rdata}, 32'hAB);

    // Wrap-around store.
    do_op(1'b0, 1'b1, 2'd2, 6'd62, 32'hDEADBEEF, lat);
    chk("ram62", {24'd0, ram[62]}, 32'hDE);
    chk("ram63", {24'd0, ram[63]}, 32'hAD);
    chk("ram0", {24'd0, ram[0]}, 32'hBE);
    chk("ram1", {24'd0, ram[1]}, 32'hEF);
    do_op(1'b0, 1'b0, 2'd2, 6'd62, 32'd0, lat);
    chk("ld_wrap", cpu_rdata, 32'hDEADBEEF);

    // Reset during the third beat of a word store.
    cnt0 = cpu_done_cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd2; cpu_addr = 6'd40; cpu_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_no_done", 32'(cpu_done_cnt), 32'(cnt0));
    chk("abort_ram40", {24'd0, ram[40]}, 32'hA1);
    chk("abort_ram41", {24'd0, ram[41]}, 32'hB2);
    chk("abort_ram42", {24'd0, ram[42]}, 32'h00);
    chk("abort_ram43", {24'd0, ram[43]}, 32'h00);
    do_op(1'b0, 1'b0, 2'd2, 6'd40, 32'd0, lat);
    chk("post_abort_lat", 32'(lat), 32'd6);
    chk("post_abort_ld", cpu_rdata, 32'hA1B20000);

    // Host request arriving during a CPU transfer.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 6'd8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd21;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cpu_done) begin lat = i; break; end
      @(posedge clk);
    end
    chk("overlap_cpu_seen", {31'd0, lat > 0}, 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (host_done) begin lat = i; break; end
      @(posedge clk);
    end
    chk("overlap_host_gap", 32'(lat), 32'd4);
    chk("overlap_host_rd", {24'd0, host_rdata}, 32'hCD);
    @(posedge clk); #1;
    host_req = 1'b0;

    // Tie from reset: grants must alternate CPU, host, CPU, host.
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 6'd8;
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    seq = 4'd0; nseq = 0;
    for (int i = 0; i < 80 && nseq < 4; i++) begin
      @(negedge clk);
      if (cpu_done) begin seq = {seq[2:0], 1'b0}; nseq++; end
      if (host_done) begin seq = {seq[2:0], 1'b1}; nseq++; end
    end
    chk("tie_count", 32'(nseq), 32'd4);
    chk("tie_order", {28'd0, seq}, 32'h5);
    chk("tie_cpu_rd", cpu_rdata, 32'h11223344);
    chk("tie_host_rd", {24'd0, host_rdata}, 32'hAB);
    @(posedge clk); #1;
    cpu_req = 1'b0; host_req = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("single_cycle_done", 32'(double_pulse), 32'd0);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
